// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, counter sizing
// and two's-complement helpers.
package div_pkg;

  // Widest operand the helpers support; callers zero-extend into this width
  // and size-cast the result back to their own WIDTH.
  localparam int MAX_W = 64;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;
  localparam state_t DONE = 2'd3;

  // Ceiling log2, used to size the bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Two's-complement negation.
  function automatic logic [MAX_W-1:0] neg(input logic [MAX_W-1:0] v);
    return -v;
  endfunction

  // Magnitude of a w-bit two's-complement value held in the low w bits of v.
  // For the most negative value the low w bits of the result are 2^(w-1),
  // which is representable as a w-bit unsigned magnitude.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                               input int w);
    return v[w-1] ? neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] part_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] part_out,
  output logic             q_bit
);

  // Widened by one bit so the shifted partial remainder never loses its MSB.
  logic [WIDTH:0] shifted;

  assign shifted  = {part_in, next_bit};
  assign q_bit    = (shifted >= {1'b0, dvs});
  // The remainder after subtraction is always below dvs, so it fits WIDTH bits.
  assign part_out = q_bit ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, optional signed mode.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high; an output transfer happens on a rising edge where
// out_valid and out_ready are both high. A valid, once raised, and its data
// are held unchanged until the matching transfer edge.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CW_RAW = clog2(WIDTH);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;
  logic             ovf_pend;
  logic [WIDTH-1:0] part_next;
  logic             q_bit;
  logic             sgn_in;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign sgn_in    = SIGNED_EN && signed_mode;

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_in  (part),
    .next_bit (dvd_mag[WIDTH-1]),
    .dvs      (dvs_mag),
    .part_out (part_next),
    .q_bit    (q_bit)
  );

  // Control FSM plus datapath registers: accept, iterate, sign-fix, hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_mag     <= '0;
      dvs_mag     <= '0;
      part        <= '0;
      quo         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              // Same result in both modes: all-ones quotient, dividend passes through.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              dvd_mag  <= sgn_in ? WIDTH'(abs_val(MAX_W'(dividend), WIDTH)) : dividend;
              dvs_mag  <= sgn_in ? WIDTH'(abs_val(MAX_W'(divisor), WIDTH)) : divisor;
              neg_q    <= sgn_in && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r    <= sgn_in && dividend[WIDTH-1];
              ovf_pend <= sgn_in && (dividend == MIN_VAL) && (divisor == '1);
              part     <= '0;
              quo      <= '0;
              cnt      <= CW'(WIDTH - 1);
              state    <= CALC;
            end
          end
        end
        CALC: begin
          part    <= part_next;
          quo     <= {quo[WIDTH-2:0], q_bit};
          dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b0};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          // Negating zero yields zero, so zero results never come out negative.
          // MIN / -1 falls out as quotient MIN because the magnitude 2^(WIDTH-1)
          // is left un-negated (both operands negative).
          quotient  <= neg_q ? WIDTH'(neg(MAX_W'(quo)))  : quo;
          remainder <= neg_r ? WIDTH'(neg(MAX_W'(part))) : part;
          overflow  <= ovf_pend;
          state     <= DONE;
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule
